// File: rtl/mode_sequencer_if.sv
// Mode sequencer bus: power/button inputs and mode/countdown outputs.
// master drives buttons, slave is the sequencer.
interface mode_sequencer_if;
  logic       machine_state;
  logic       menu_btn;
  logic       mode1_btn;
  logic       mode2_btn;
  logic       mode3_btn;
  logic       mode_self_clean_btn;
  logic [2:0] mode_state;
  logic [7:0] countdown_sec;
  logic       clean_done;

  modport master (
    output machine_state, menu_btn, mode1_btn,
    output mode2_btn, mode3_btn, mode_self_clean_btn,
    input  mode_state, countdown_sec, clean_done
  );

  modport slave (
    input  machine_state, menu_btn, mode1_btn,
    input  mode2_btn, mode3_btn, mode_self_clean_btn,
    output mode_state, countdown_sec, clean_done
  );
endinterface

// File: rtl/mode_sequencer.sv
// Fan mode sequencer: gears 1-3, drain run-down and timed self-clean.
// Buttons act on rising edges; gear 3 usable once per power-on.
module mode_sequencer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int GEAR3_SEC     = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int DRAIN_SEC     = 60
) (
  input  logic             clk,
  input  logic             reset,
  mode_sequencer_if.slave  bus
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);

  localparam logic [7:0] G3_N =
    (GEAR3_SEC > 255) ? 8'd255 : 8'(GEAR3_SEC);
  localparam logic [7:0] CLEAN_N =
    (CLEAN_SEC > 255) ? 8'd255 : 8'(CLEAN_SEC);
  localparam logic [7:0] DRAIN_N =
    (DRAIN_SEC > 255) ? 8'd255 : 8'(DRAIN_SEC);

  localparam int B_M1    = 0;
  localparam int B_M2    = 1;
  localparam int B_M3    = 2;
  localparam int B_CLEAN = 3;
  localparam int B_MENU  = 4;

  typedef enum logic [2:0] {
    ST_STANDBY,
    ST_G1,
    ST_G2,
    ST_G3,
    ST_DRAIN,
    ST_CLEAN
  } state_t;

  state_t          state;
  logic [CW-1:0]   tick;
  logic [7:0]      cd;
  logic            g3_used;
  logic [4:0]      btn;
  logic [4:0]      btn_q;
  logic [4:0]      ev;
  logic            wrap;

  // Button rising edges and second-boundary detect.
  always_comb begin
    btn = {bus.menu_btn, bus.mode_self_clean_btn,
           bus.mode3_btn, bus.mode2_btn, bus.mode1_btn};
    ev   = btn & ~btn_q;
    wrap = (tick == TICK_LAST);
  end

  assign bus.countdown_sec = cd;

  // Mode FSM with tick counter, countdown and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_STANDBY;
      bus.mode_state <= 3'b000;
      bus.clean_done <= 1'b0;
      tick           <= '0;
      cd             <= 8'd0;
      g3_used        <= 1'b0;
      btn_q          <= 5'b0;
    end else begin
      btn_q          <= btn;
      bus.clean_done <= 1'b0;
      if (!bus.machine_state) begin
        state          <= ST_STANDBY;
        bus.mode_state <= 3'b000;
        tick           <= '0;
        cd             <= 8'd0;
        g3_used        <= 1'b0;
      end else begin
        unique case (state)
          ST_STANDBY: begin
            if (ev[B_CLEAN]) begin
              state          <= ST_CLEAN;
              bus.mode_state <= 3'b100;
              tick           <= '0;
              cd             <= CLEAN_N;
            end else if (ev[B_M3] && !g3_used) begin
              state          <= ST_G3;
              bus.mode_state <= 3'b011;
              tick           <= '0;
              cd             <= G3_N;
              g3_used        <= 1'b1;
            end else if (ev[B_M2]) begin
              state          <= ST_G2;
              bus.mode_state <= 3'b010;
            end else if (ev[B_M1]) begin
              state          <= ST_G1;
              bus.mode_state <= 3'b001;
            end
          end
          ST_G1, ST_G2: begin
            if (ev[B_MENU]) begin
              state          <= ST_STANDBY;
              bus.mode_state <= 3'b000;
            end else if (ev[B_M2]) begin
              state          <= ST_G2;
              bus.mode_state <= 3'b010;
            end else if (ev[B_M1]) begin
              state          <= ST_G1;
              bus.mode_state <= 3'b001;
            end
          end
          ST_G3, ST_DRAIN, ST_CLEAN: begin
            if (state == ST_G3 && ev[B_MENU]) begin
              state          <= ST_DRAIN;
              bus.mode_state <= 3'b010;
              tick           <= '0;
              cd             <= DRAIN_N;
            end else if (wrap) begin
              tick <= '0;
              if (cd <= 8'd1) begin
                state          <= ST_STANDBY;
                bus.mode_state <= 3'b000;
                cd             <= 8'd0;
                bus.clean_done <= (state == ST_CLEAN);
              end else begin
                cd <= cd - 8'd1;
              end
            end else begin
              tick <= tick + CW'(1);
            end
          end
          default: begin
            state          <= ST_STANDBY;
            bus.mode_state <= 3'b000;
            tick           <= '0;
            cd             <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule
